// File: rtl/fp_arb_pkg.sv
// Shared types and defaults for the floating-point unit sharing arbiter.
package fp_arb_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned LAT_DEF  = 3;
    localparam int unsigned IW_DEF   = 2;
    localparam int unsigned DW       = 32;
    // Tag index is sized for the largest legal NREQ (8) so one type serves every instance
    localparam int unsigned TIW      = 3;

    typedef struct packed {
        logic           valid;
        logic [TIW-1:0] idx;
    } tag_t;

endpackage

// File: rtl/fp_share_arb_rr_pick.sv
// Rotate-and-priority-encode: first set bit of elig at or above ptr, wrapping at NREQ.
module rr_pick
    import fp_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IW   = IW_DEF
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   win_c,
    output logic            found_c
);

    always_comb begin
        int unsigned s;
        s       = 0;
        win_c   = '0;
        found_c = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            s = 32'(ptr) + i;
            if (s >= NREQ) s = s - NREQ;
            if (!found_c && elig[IW'(s)]) begin
                found_c = 1'b1;
                win_c   = IW'(s);
            end
        end
    end

endmodule

// File: rtl/fp_share_arb.sv
// Round-robin arbiter sharing one pipelined FP unit among NREQ requesters.
// FP_ARB_PRIO0_EN: requester 0 gets fixed top priority; others rotate.
module fp_share_arb
    import fp_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned LAT  = LAT_DEF,
    parameter int unsigned IW   = IW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*DW-1:0] opa,
    input  logic [NREQ*DW-1:0] opb,
    output logic [NREQ-1:0]  gnt,
    output logic [DW-1:0]    unit_a,
    output logic [DW-1:0]    unit_b,
    input  logic [DW-1:0]    unit_res,
    output logic [DW-1:0]    res,
    output logic [NREQ-1:0]  rvalid,
    output logic             busy
);

    logic [IW-1:0]   ptr;
    tag_t            tags [LAT];

    logic [NREQ-1:0] elig_c;
    logic [NREQ-1:0] rr_elig_c;
    logic [IW-1:0]   rr_win_c;
    logic            rr_found_c;
    logic [IW-1:0]   win_c;
    logic            found_c;
    logic            upd_ptr_c;
    logic [IW-1:0]   ptr_nxt_c;
    logic            inflight_c;

    // A requester granted last cycle sits out one cycle
    assign elig_c = req & ~gnt;

`ifdef FP_ARB_PRIO0_EN
    assign rr_elig_c = elig_c & ~NREQ'(1);
`else
    assign rr_elig_c = elig_c;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .elig    (rr_elig_c),
        .ptr     (ptr),
        .win_c   (rr_win_c),
        .found_c (rr_found_c)
    );

    always_comb begin
        win_c     = rr_win_c;
        found_c   = rr_found_c;
        upd_ptr_c = rr_found_c;
`ifdef FP_ARB_PRIO0_EN
        if (elig_c[0]) begin
            win_c     = '0;
            found_c   = 1'b1;
            upd_ptr_c = 1'b0;
        end
`endif
    end

    always_comb begin
        ptr_nxt_c = '0;
        if (32'(win_c) + 1 < NREQ) ptr_nxt_c = win_c + IW'(1);
    end

    // Issue this cycle or anything still short of the last stage keeps busy high
    always_comb begin
        inflight_c = 1'b0;
        for (int unsigned i = 0; i + 1 < LAT; i++) inflight_c = inflight_c | tags[i].valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            gnt    <= '0;
            unit_a <= '0;
            unit_b <= '0;
            res    <= '0;
            rvalid <= '0;
            busy   <= 1'b0;
            for (int unsigned i = 0; i < LAT; i++) tags[i] <= '0;
        end else begin
            gnt  <= found_c ? (NREQ'(1) << win_c) : '0;
            busy <= found_c | inflight_c;
            if (found_c) begin
                unit_a <= opa[DW*32'(win_c) +: DW];
                unit_b <= opb[DW*32'(win_c) +: DW];
            end
            if (upd_ptr_c) ptr <= ptr_nxt_c;

            tags[0].valid <= found_c;
            tags[0].idx   <= TIW'(win_c);
            for (int unsigned i = 1; i < LAT; i++) tags[i] <= tags[i-1];

            if (tags[LAT-1].valid) begin
                res    <= unit_res;
                rvalid <= NREQ'(1) << tags[LAT-1].idx;
            end else begin
                rvalid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fp_share_arb.sv
// Directed, table-driven bench for fp_share_arb with a LAT=3 FP adder model.
module tb_fp_share_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned LAT  = 3;
    localparam int unsigned IW   = 2;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] opa;
    logic [NREQ*32-1:0] opb;
    logic [NREQ-1:0]    gnt;
    logic [31:0]        unit_a;
    logic [31:0]        unit_b;
    logic [31:0]        unit_res;
    logic [31:0]        res;
    logic [NREQ-1:0]    rvalid;
    logic               busy;

    fp_share_arb #(.NREQ(NREQ), .LAT(LAT), .IW(IW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .opa      (opa),
        .opb      (opb),
        .gnt      (gnt),
        .unit_a   (unit_a),
        .unit_b   (unit_b),
        .unit_res (unit_res),
        .res      (res),
        .rvalid   (rvalid),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Normal single-precision operands only; exact sums
    function automatic logic [63:0] s2d(input logic [31:0] s);
        if (s[30:0] == 31'd0) return {s[31], 63'd0};
        return {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] d2s(input logic [63:0] d);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return d2s($realtobits($bitstoreal(s2d(a)) + $bitstoreal(s2d(b))));
    endfunction

    // Shared adder: operands held in cycle c give a result in cycle c+LAT-1
    logic [31:0] p1, p2;
    always @(posedge clk) begin
        p1 <= fadd(unit_a, unit_b);
        p2 <= p1;
    end
    assign unit_res = p2;

    logic [31:0] op_a_tab [NREQ];
    logic [31:0] op_b_tab [NREQ];

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic [3:0]  rvalid;
        logic [31:0] res;
        logic        busy;
    } vec_t;

    vec_t vq[$];
    int   n_cmp;
    int   n_err;

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] g, input logic [3:0] v,
                                input logic [31:0] rs, input logic b);
        vec_t x;
        x.req = r; x.gnt = g; x.rvalid = v; x.res = rs; x.busy = b;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " gnt"},    32'(gnt),    32'd0);
        chk({tag, " rvalid"}, 32'(rvalid), 32'd0);
        chk({tag, " res"},    res,         32'd0);
        chk({tag, " unit_a"}, unit_a,      32'd0);
        chk({tag, " unit_b"}, unit_b,      32'd0);
        chk({tag, " busy"},   32'(busy),   32'd0);
    endtask

    logic [3:0]  g_a, g_b, g1, g2;
    logic [31:0] res_a, res_b;

    initial begin
        n_cmp = 0;
        n_err = 0;
        op_a_tab[0] = 32'h3F800000; op_b_tab[0] = 32'h3F800000;  // 1+1 = 2
        op_a_tab[1] = 32'h3F800000; op_b_tab[1] = 32'h40000000;  // 1+2 = 3
        op_a_tab[2] = 32'h40000000; op_b_tab[2] = 32'h40000000;  // 2+2 = 4
        op_a_tab[3] = 32'h40A00000; op_b_tab[3] = 32'h40400000;  // 5+3 = 8
        opa = {op_a_tab[3], op_a_tab[2], op_a_tab[1], op_a_tab[0]};
        opb = {op_b_tab[3], op_b_tab[2], op_b_tab[1], op_b_tab[0]};
        req   = '0;
        rst_n = 1'b0;

        // Single requester at t0=0, second single at t0+5 (idle-gap busy windows)
        vq.push_back(mk(4'b0010, 4'b0000, 4'b0000, 32'h0, 1'b0));
        vq.push_back(mk(4'b0000, 4'b0010, 4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0000, 4'b0010, 32'h40400000, 1'b0));
        vq.push_back(mk(4'b1000, 4'b0000, 4'b0000, 32'h0, 1'b0));
        vq.push_back(mk(4'b0000, 4'b1000, 4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0000, 4'b1000, 32'h41000000, 1'b0));
        // Full contention, pointer at 0
        vq.push_back(mk(4'b1111, 4'b0000, 4'b0000, 32'h0, 1'b0));
`ifdef FP_ARB_PRIO0_EN
        vq.push_back(mk(4'b1111, 4'b0001, 4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b1111, 4'b0010, 4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b1111, 4'b0001, 4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b1111, 4'b0100, 4'b0001, 32'h40000000, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0001, 4'b0010, 32'h40400000, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0000, 4'b0001, 32'h40000000, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0000, 4'b0100, 32'h40800000, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0000, 4'b0001, 32'h40000000, 1'b0));
        g_a = 4'b0001; res_a = 32'h40000000;
        g_b = 4'b1000; res_b = 32'h41000000;
`else
        vq.push_back(mk(4'b1111, 4'b0001, 4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b1111, 4'b0010, 4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b1111, 4'b0100, 4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b1111, 4'b1000, 4'b0001, 32'h40000000, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0001, 4'b0010, 32'h40400000, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0000, 4'b0100, 32'h40800000, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0000, 4'b1000, 32'h41000000, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0000, 4'b0001, 32'h40000000, 1'b0));
        g_a = 4'b1000; res_a = 32'h41000000;
        g_b = 4'b0001; res_b = 32'h40000000;
`endif
        // req[2] held alone: grant on alternate cycles
        vq.push_back(mk(4'b0100, 4'b0000, 4'b0000, 32'h0, 1'b0));
        vq.push_back(mk(4'b0100, 4'b0100, 4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b0100, 4'b0000, 4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b0100, 4'b0100, 4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b0100, 4'b0000, 4'b0100, 32'h40800000, 1'b1));
        vq.push_back(mk(4'b0100, 4'b0100, 4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0000, 4'b0100, 32'h40800000, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0000, 4'b0100, 32'h40800000, 1'b0));
        // req[0] and req[3] held together
        vq.push_back(mk(4'b1001, 4'b0000, 4'b0000, 32'h0, 1'b0));
        vq.push_back(mk(4'b1001, g_a,     4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b1001, g_b,     4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b1001, g_a,     4'b0000, 32'h0, 1'b1));
        vq.push_back(mk(4'b0000, g_b,     g_a,     res_a, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0000, g_b,     res_b, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0000, g_a,     res_a, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0000, g_b,     res_b, 1'b0));
        vq.push_back(mk(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0));

        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("gnt@%0d", i),    32'(gnt),    32'(vq[i].gnt));
            chk($sformatf("rvalid@%0d", i), 32'(rvalid), 32'(vq[i].rvalid));
            chk($sformatf("busy@%0d", i),   32'(busy),   32'(vq[i].busy));
            if (vq[i].rvalid != 4'b0000)
                chk($sformatf("res@%0d", i), res, vq[i].res);
            for (int k = 0; k < 4; k++) begin
                if (vq[i].gnt[k]) begin
                    chk($sformatf("unit_a@%0d", i), unit_a, op_a_tab[k]);
                    chk($sformatf("unit_b@%0d", i), unit_b, op_b_tab[k]);
                end
            end
            req = vq[i].req;
        end

        // Two issues in flight, then reset
        @(posedge clk); #1; req = 4'b0011;
        @(posedge clk); #1; g1 = gnt;
        @(posedge clk); #1; g2 = gnt; req = 4'b0000;
        chk("midflight issued", 32'(g1 | g2), 32'h3);
        chk("midflight busy",   32'(busy),    32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midflight reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk($sformatf("post-reset rvalid@%0d", i), 32'(rvalid), 32'd0);
            chk($sformatf("post-reset busy@%0d", i),   32'(busy),   32'd0);
        end

        // Pointer restarts at 0 after reset
        req = 4'b1111;
        @(posedge clk); #1;
        chk("post-reset first gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk("post-reset rvalid", 32'(rvalid), 32'h1);
        chk("post-reset res",    res,         32'h40000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
